// File: rtl/ddr3_cmd_scheduler_if.sv
// Requester ports and DDR3 command pins of the post-init scheduler.
// slave = scheduler side, master = requester/PHY side.
interface ddr3_cmd_scheduler_if;
  logic        p0_req;
  logic        p0_we;
  logic [2:0]  p0_ba;
  logic [13:0] p0_row;
  logic [9:0]  p0_col;
  logic        p0_ack;
  logic        p1_req;
  logic        p1_we;
  logic [2:0]  p1_ba;
  logic [13:0] p1_row;
  logic [9:0]  p1_col;
  logic        p1_ack;
  logic [2:0]  cmd;
  logic        cs_n;
  logic [2:0]  ba;
  logic [13:0] addr;

  modport slave (
    input  p0_req, p0_we, p0_ba, p0_row, p0_col,
    input  p1_req, p1_we, p1_ba, p1_row, p1_col,
    output p0_ack, p1_ack, cmd, cs_n, ba, addr
  );

  modport master (
    output p0_req, p0_we, p0_ba, p0_row, p0_col,
    output p1_req, p1_we, p1_ba, p1_row, p1_col,
    input  p0_ack, p1_ack, cmd, cs_n, ba, addr
  );
endinterface

// File: rtl/ddr3_cmd_scheduler.sv
// Post-init DDR3 command scheduler: two-port round-robin,
// closed-page ACT/RD-WR/PRE accesses and periodic refresh.
module ddr3_cmd_scheduler #(
  parameter int T_RCD   = 6,
  parameter int T_RAS   = 15,
  parameter int T_RTP   = 4,
  parameter int T_WRPRE = 15,
  parameter int T_RP    = 6,
  parameter int T_RFC   = 88,
  parameter int T_REFI  = 6240
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  ddr3_cmd_scheduler_if.slave   bus,
  output logic                  ref_overflow
);

  localparam int TW = $clog2(T_REFI);

  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_REF,
    S_RCD,
    S_POST,
    S_RP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ras_q, ras_d;
  logic [3:0]  debt_q, debt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        ovf_q, ovf_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [2:0]  lba_q, lba_d;
  logic [13:0] row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        cs_n_q, cs_n_d;
  logic [2:0]  ba_q, ba_d;
  logic [13:0] addr_q, addr_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;

  logic        run;
  logic        expire;
  logic        ref_issue;
  logic        sel;

  // Next-state, command decision, refresh timer and debt.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 16'd1 : '0;
    ras_d     = (ras_q != '0) ? ras_q - 16'd1 : '0;
    debt_d    = debt_q;
    ovf_d     = ovf_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    lba_d     = lba_q;
    row_d     = row_q;
    col_d     = col_q;
    cmd_d     = C_NOP;
    cs_n_d    = cs_n_q;
    ba_d      = '0;
    addr_d    = '0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    ref_issue = 1'b0;
    sel       = ptr_q;

    run     = (state_q != S_WAIT_INIT);
    expire  = run && (timer_q == TW'(T_REFI - 1));
    timer_d = (!run || expire) ? '0 : timer_q + 1'b1;

    unique case (state_q)
      S_WAIT_INIT: begin
        if (init_done) begin
          state_d = S_IDLE;
          cs_n_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (debt_q != '0) begin
          cmd_d     = C_REF;
          ref_issue = 1'b1;
          state_d   = S_REF;
          cnt_d     = 16'(T_RFC - 1);
        end else if (bus.p0_req || bus.p1_req) begin
          sel    = (bus.p0_req && bus.p1_req) ? ptr_q : bus.p1_req;
          ptr_d  = ~sel;
          gnt_d  = sel;
          we_d   = sel ? bus.p1_we  : bus.p0_we;
          lba_d  = sel ? bus.p1_ba  : bus.p0_ba;
          row_d  = sel ? bus.p1_row : bus.p0_row;
          col_d  = sel ? bus.p1_col : bus.p0_col;
          cmd_d  = C_ACT;
          ba_d   = sel ? bus.p1_ba  : bus.p0_ba;
          addr_d = sel ? bus.p1_row : bus.p0_row;
          state_d = S_RCD;
          cnt_d  = 16'(T_RCD - 1);
          ras_d  = 16'(T_RAS - 1);
        end
      end
      S_REF: begin
        if (cnt_q <= 16'd1) state_d = S_IDLE;
      end
      S_RCD: begin
        if (cnt_q == '0) begin
          cmd_d   = we_q ? C_WR : C_RD;
          ba_d    = lba_q;
          addr_d  = {4'b0000, col_q};
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_POST;
          cnt_d   = we_q ? 16'(T_WRPRE - 1) : 16'(T_RTP - 1);
        end
      end
      S_POST: begin
        if (cnt_q == '0 && ras_q == '0) begin
          cmd_d   = C_PRE;
          ba_d    = lba_q;
          state_d = S_RP;
          cnt_d   = 16'(T_RP - 1);
        end
      end
      S_RP: begin
        if (cnt_q <= 16'd1) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_INIT;
    endcase

    if (expire && !ref_issue) begin
      if (debt_q == 4'd8) ovf_d = 1'b1;
      else                debt_d = debt_q + 4'd1;
    end else if (!expire && ref_issue) begin
      debt_d = debt_q - 4'd1;
    end
  end

  // State and registered pins; rst restores the idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT_INIT;
      cnt_q   <= '0;
      ras_q   <= '0;
      debt_q  <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      lba_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cmd_q   <= C_NOP;
      cs_n_q  <= 1'b1;
      ba_q    <= '0;
      addr_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ras_q   <= ras_d;
      debt_q  <= debt_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      lba_q   <= lba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cmd_q   <= cmd_d;
      cs_n_q  <= cs_n_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign bus.cmd      = cmd_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.ba       = ba_q;
  assign bus.addr     = addr_q;
  assign bus.p0_ack   = ack0_q;
  assign bus.p1_ack   = ack1_q;
  assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// Directed bench for ddr3_cmd_scheduler with an access scoreboard.
// Instance a: T_REFI=100; instance b: fast refresh for overflow.
module tb_ddr3_cmd_scheduler;

  localparam int T_RCD   = 6;
  localparam int T_RAS   = 15;
  localparam int T_RTP   = 4;
  localparam int T_WRPRE = 15;
  localparam int T_RP    = 6;
  localparam int T_RFC   = 88;

  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  ba;
    logic [13:0] row;
    logic [9:0]  col;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic init_done;
  logic ovf_a;
  logic ovf_b;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic rr_ptr;

  ddr3_cmd_scheduler_if ia ();
  ddr3_cmd_scheduler_if ib ();

  ddr3_cmd_scheduler #(.T_REFI(100)) dut_a (
    .clk(clk), .rst(rst), .init_done(init_done),
    .bus(ia.slave), .ref_overflow(ovf_a)
  );

  ddr3_cmd_scheduler #(.T_REFI(10), .T_RFC(150)) dut_b (
    .clk(clk), .rst(rst), .init_done(init_done),
    .bus(ib.slave), .ref_overflow(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cmd(output logic [2:0] c, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ia.cmd == C_NOP && n < 400);
    c  = ia.cmd;
    at = cyc;
    if (c == C_NOP) chk("cmd_timeout", 32'(c != C_NOP), 1);
  endtask

  task automatic next_nonref(output logic [2:0] c, output int at,
                             output bit had_ref);
    had_ref = 1'b0;
    next_cmd(c, at);
    for (int k = 0; k < 8 && c == C_REF; k++) begin
      had_ref = 1'b1;
      next_cmd(c, at);
    end
  endtask

  task automatic do_access(output int t_act, output bit had_ref);
    exp_t e;
    logic [2:0] c;
    int at;
    int t_pre;
    e = sb.pop_front();
    next_nonref(c, at, had_ref);
    t_act = at;
    chk("act_cmd", c, C_ACT);
    chk("act_ba", ia.ba, e.ba);
    chk("act_addr", ia.addr, e.row);
    next_cmd(c, at);
    chk("rw_cmd", c, e.we ? C_WR : C_RD);
    chk("rw_time", at - t_act, T_RCD);
    chk("rw_ba", ia.ba, e.ba);
    chk("rw_addr", ia.addr, {4'b0000, e.col});
    chk("ack_port", {ia.p1_ack, ia.p0_ack}, e.port ? 2'b10 : 2'b01);
    @(negedge clk);
    chk("ack_pulse", {ia.p1_ack, ia.p0_ack}, 2'b00);
    next_cmd(c, at);
    t_pre = T_RCD + (e.we ? T_WRPRE : T_RTP);
    if (t_pre < T_RAS) t_pre = T_RAS;
    chk("pre_cmd", c, C_PRE);
    chk("pre_ba", ia.ba, e.ba);
    chk("pre_addr", ia.addr, 0);
    chk("pre_time", at - t_act, t_pre);
  endtask

  task automatic push_req(input logic port, input logic we,
                          input logic [2:0] ba, input logic [13:0] row,
                          input logic [9:0] col);
    exp_t e;
    e.port = port;
    e.we   = we;
    e.ba   = ba;
    e.row  = row;
    e.col  = col;
    sb.push_back(e);
  endtask

  initial begin
    logic [2:0] c;
    int at, t0, t1, t2, r, last_pre, n;
    bit hr, have_pre, seen, rd_seen, hit;
    logic g;

    rst = 1'b1;
    init_done = 1'b0;
    ia.p0_req = 0; ia.p0_we = 0; ia.p0_ba = 0; ia.p0_row = 0; ia.p0_col = 0;
    ia.p1_req = 0; ia.p1_we = 0; ia.p1_ba = 0; ia.p1_row = 0; ia.p1_col = 0;
    ib.p0_req = 0; ib.p0_we = 0; ib.p0_ba = 0; ib.p0_row = 0; ib.p0_col = 0;
    ib.p1_req = 0; ib.p1_we = 0; ib.p1_ba = 0; ib.p1_row = 0; ib.p1_col = 0;
    rr_ptr = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_cmd", ia.cmd, C_NOP);
    chk("rst_cs_n", ia.cs_n, 1);
    chk("rst_ack", {ia.p1_ack, ia.p0_ack}, 0);
    chk("rst_ba", ia.ba, 0);
    chk("rst_addr", ia.addr, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_init_cs_n", ia.cs_n, 1);
    init_done = 1'b1;
    @(negedge clk);
    chk("init_cs_n", ia.cs_n, 0);
    chk("init_cmd", ia.cmd, C_NOP);

    // Refresh debt saturation on instance b
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      hit = (ib.cmd == C_REF);
    end
    chk("b_ref_seen", hit, 1);
    repeat (80) @(negedge clk);
    chk("b_ovf_debt8", ovf_b, 0);
    repeat (15) @(negedge clk);
    chk("b_ovf_set", ovf_b, 1);
    chk("a_ovf_clear", ovf_a, 0);
    repeat (10) @(negedge clk);
    chk("b_ovf_sticky", ovf_b, 1);

    // Single read on p0
    push_req(1'b0, 1'b0, 3'd2, 14'h1234, 10'h010);
    ia.p0_we = 0; ia.p0_ba = 3'd2; ia.p0_row = 14'h1234; ia.p0_col = 10'h010;
    ia.p0_req = 1;
    rr_ptr = 1'b1;
    do_access(t0, hr);
    ia.p0_req = 0;

    // Single write on p1
    push_req(1'b1, 1'b1, 3'd5, 14'd7, 10'h3F8);
    ia.p1_we = 1; ia.p1_ba = 3'd5; ia.p1_row = 14'd7; ia.p1_col = 10'h3F8;
    ia.p1_req = 1;
    rr_ptr = 1'b0;
    do_access(t1, hr);
    ia.p1_req = 0;
    if (hr) chk("rd_act_gap_min", 32'((t1 - t0) >= 21), 1);
    else    chk("rd_act_gap", t1 - t0, 21);

    // Round-robin with both ports held
    ia.p0_we = 0; ia.p0_ba = 3'd1; ia.p0_row = 14'h0AAA; ia.p0_col = 10'h055;
    ia.p1_we = 1; ia.p1_ba = 3'd6; ia.p1_row = 14'h3FFF; ia.p1_col = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      g = rr_ptr;
      if (g) push_req(1'b1, 1'b1, 3'd6, 14'h3FFF, 10'h3FF);
      else   push_req(1'b0, 1'b0, 3'd1, 14'h0AAA, 10'h055);
      rr_ptr = ~g;
    end
    ia.p0_req = 1;
    ia.p1_req = 1;
    for (int i = 0; i < 4; i++) begin
      do_access(t2, hr);
      if (i == 0) begin
        if (hr) chk("wr_idle_gap_min", 32'((t2 - t1) >= 27), 1);
        else    chk("wr_idle_gap", t2 - t1, 27);
      end
    end
    ia.p0_req = 0;
    ia.p1_req = 0;

    // Refresh inside a long p0 read stream
    ia.p0_we = 0; ia.p0_ba = 3'd0; ia.p0_row = 14'h0001; ia.p0_col = 10'h000;
    ia.p0_req = 1;
    have_pre = 0;
    seen = 0;
    last_pre = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      next_cmd(c, at);
      if (c == C_PRE) begin
        last_pre = at;
        have_pre = 1;
      end else if (c == C_REF && have_pre) begin
        seen = 1;
        chk("ref_after_pre", at - last_pre, T_RP);
        r = at;
        next_cmd(c, at);
        chk("ref_quiet", at - r, T_RFC);
        chk("ref_resume_cmd", 32'((c == C_ACT) || (c == C_REF)), 1);
      end
    end
    chk("ref_seen", seen, 1);
    rd_seen = 0;
    n = 0;
    do begin
      next_cmd(c, at);
      if (c == C_RD) rd_seen = 1;
      n++;
    end while (!(c == C_PRE && rd_seen) && n < 20);
    chk("ref_resume_rd", rd_seen, 1);
    ia.p0_req = 0;

    // Reset pulse during RCD wait
    ia.p1_we = 0; ia.p1_ba = 3'd3; ia.p1_row = 14'h0100; ia.p1_col = 10'h020;
    ia.p1_req = 1;
    next_nonref(c, at, hr);
    chk("mid_act", c, C_ACT);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd", ia.cmd, C_NOP);
    chk("mid_rst_cs_n", ia.cs_n, 1);
    chk("mid_rst_ba", ia.ba, 0);
    chk("mid_rst_addr", ia.addr, 0);
    chk("mid_rst_ack", {ia.p1_ack, ia.p0_ack}, 0);
    chk("mid_rst_ovf_b", ovf_b, 0);
    rst = 1'b0;
    ia.p1_req = 0;
    rr_ptr = 1'b0;
    hit = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ia.cmd == C_RD || ia.cmd == C_WR || ia.p0_ack || ia.p1_ack)
        hit = 1;
    end
    chk("mid_no_rw", hit, 0);
    chk("mid_cs_n_back", ia.cs_n, 0);

    // Pointer back at port 0 after reset
    ia.p0_we = 1; ia.p0_ba = 3'd7; ia.p0_row = 14'h2000; ia.p0_col = 10'h200;
    for (int i = 0; i < 2; i++) begin
      g = rr_ptr;
      if (g) push_req(1'b1, 1'b0, 3'd3, 14'h0100, 10'h020);
      else   push_req(1'b0, 1'b1, 3'd7, 14'h2000, 10'h200);
      rr_ptr = ~g;
    end
    ia.p0_req = 1;
    ia.p1_req = 1;
    do_access(t0, hr);
    ia.p0_req = 0;
    do_access(t0, hr);
    ia.p1_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
